// File: rtl/nibble_serial_adder_if.sv
// Request/response bundle between a requester and nibble_serial_adder.
// NIBBLE_SERIAL_SUBTRACT_EN adds the Sub request bit.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
    logic             Sub;
`endif
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
        output Sub,
`endif
        output Start, A, B, Cin,
        input  Busy, Done, Sum, Cout
    );

    modport slave (
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
        input  Sub,
`endif
        input  Start, A, B, Cin,
        output Busy, Done, Sum, Cout
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder that sequences operands one nibble per cycle through a single 4-bit CLA.
// Optional NIBBLE_SERIAL_SUBTRACT_EN adds a Sub request bit for A - B - Cin.
module cla4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [4:0] Result
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is formed directly from generate/propagate terms, not rippled.
    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign Result = {w_c[4], w_p ^ w_c[3:0]};
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    nibble_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_sub;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;
    logic [3:0]       w_a_nib [N];
    logic [3:0]       w_b_nib [N];
    logic [3:0]       w_cla_a;
    logic [3:0]       w_cla_b;
    logic [4:0]       w_cla_res;
    logic [WIDTH-1:0] w_acc_next;

`ifdef NIBBLE_SERIAL_SUBTRACT_EN
    assign w_sub = bus.Sub;
`else
    assign w_sub = 1'b0;
`endif
    // Subtraction is A + ~B + ~Cin, so Cout reads as "no borrow".
    assign w_b_in   = w_sub ? ~bus.B   : bus.B;
    assign w_cin_in = w_sub ? ~bus.Cin : bus.Cin;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_nib
            assign w_a_nib[gi] = r_a[4*gi +: 4];
            assign w_b_nib[gi] = r_b[4*gi +: 4];
            assign w_acc_next[4*gi +: 4] = (r_cnt == CW'(gi)) ? w_cla_res[3:0]
                                                              : r_acc[4*gi +: 4];
        end
    endgenerate

    assign w_cla_a = w_a_nib[r_cnt];
    assign w_cla_b = w_b_nib[r_cnt];

    cla4 u_cla (
        .A      (w_cla_a),
        .B      (w_cla_b),
        .Cin    (r_carry),
        .Result (w_cla_res)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.Start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.Busy = (r_state == S_RUN);
        bus.Done = (r_state == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_a     <= bus.A;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cla_res[4];
                    if (r_cnt == LAST) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_cla_res[4];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Sum  = r_sum;
    assign bus.Cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder against an arithmetic model.
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
        logic [WIDTH:0] r;
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end else begin
            r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            r[WIDTH] = ~r[WIDTH];
        end
        return r;
    endfunction

    task automatic drive_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub);
        bus.A   = a;
        bus.B   = b;
        bus.Cin = cin;
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
        bus.Sub = sub;
`else
        if (sub) $display("note: subtract request ignored in add-only build");
`endif
    endtask

    task automatic scramble();
        bus.A   = WIDTH'($urandom);
        bus.B   = WIDTH'($urandom);
        bus.Cin = 1'($urandom);
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
        bus.Sub = 1'($urandom);
`endif
    endtask

    // Called in the first RUN cycle; returns in the Done cycle.
    task automatic wait_result(input string tag, input logic [WIDTH:0] res);
        for (int i = 0; i < N; i++) begin
            check_eq({tag, ".busy"}, 32'(bus.Busy), 32'd1);
            check_eq({tag, ".nodone"}, 32'(bus.Done), 32'd0);
            check_eq({tag, ".hold_sum"}, 32'(bus.Sum), 32'(exp_sum));
            check_eq({tag, ".hold_cout"}, 32'(bus.Cout), 32'(exp_cout));
            scramble();
            tick();
        end
        exp_sum  = res[WIDTH-1:0];
        exp_cout = res[WIDTH];
        check_eq({tag, ".done"}, 32'(bus.Done), 32'd1);
        check_eq({tag, ".busy_lo"}, 32'(bus.Busy), 32'd0);
        check_eq({tag, ".sum"}, 32'(bus.Sum), 32'(exp_sum));
        check_eq({tag, ".cout"}, 32'(bus.Cout), 32'(exp_cout));
    endtask

    task automatic start_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub);
        logic [WIDTH:0] res;
        res = model(a, b, cin, sub);
        drive_req(a, b, cin, sub);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        wait_result(tag, res);
        $display("op %s a=0x%04h b=0x%04h cin=%0d sub=%0d -> sum=0x%04h cout=%0d", tag, a, b, cin, sub,
                 bus.Sum, bus.Cout);
        tick();
        check_eq({tag, ".pulse"}, 32'(bus.Done), 32'd0);
    endtask

    initial begin
        int last_done;
        RST       = 1'b1;
        bus.Start = 1'b0;
        drive_req('0, '0, 1'b0, 1'b0);
        exp_sum  = '0;
        exp_cout = 1'b0;
        tick();
        tick();
        check_eq("rst.busy", 32'(bus.Busy), 32'd0);
        check_eq("rst.done", 32'(bus.Done), 32'd0);
        check_eq("rst.sum", 32'(bus.Sum), 32'd0);
        check_eq("rst.cout", 32'(bus.Cout), 32'd0);
        RST = 1'b0;
        tick();
        check_eq("idle.busy", 32'(bus.Busy), 32'd0);

        start_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
        start_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        start_op("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        start_op("msb_carry", 16'h8000, 16'h8000, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            start_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        end

        // Start held high: only the IDLE-cycle operands may be used.
        bus.Start = 1'b1;
        last_done = 0;
        for (int op = 0; op < 4; op++) begin
            logic [WIDTH-1:0] a, b;
            logic             c;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            c = 1'($urandom);
            drive_req(a, b, c, 1'b0);
            tick();
            wait_result("held", model(a, b, c, 1'b0));
            $display("op held a=0x%04h b=0x%04h cin=%0d -> sum=0x%04h cout=%0d", a, b, c,
                     bus.Sum, bus.Cout);
            if (op > 0) check_eq("held.spacing", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
            scramble();
            tick();
            check_eq("held.idle", 32'(bus.Done), 32'd0);
        end
        bus.Start = 1'b0;
        tick();

        // Abort in the second RUN cycle.
        drive_req(16'h00FF, 16'h0001, 1'b0, 1'b0);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        check_eq("abort.busy_pre", 32'(bus.Busy), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        check_eq("abort.busy", 32'(bus.Busy), 32'd0);
        check_eq("abort.done", 32'(bus.Done), 32'd0);
        check_eq("abort.sum", 32'(bus.Sum), 32'd0);
        check_eq("abort.cout", 32'(bus.Cout), 32'd0);
        for (int i = 0; i < N + 2; i++) begin
            tick();
            check_eq("abort.quiet", 32'(bus.Done), 32'd0);
        end
        $display("op abort a=0x00ff b=0x0001 -> aborted, sum=0x%04h", bus.Sum);
        start_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_SUBTRACT_EN
        start_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
        start_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            start_op("sub_rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that drives one instance of the team's 4-bit CLA (ports A[3:0], B[3:0], Cin, Result[4:0]).
- Each cycle it feeds the CLA one nibble of the operands, captures the nibble sum, and registers the carry for the next nibble.
- Acts as the sequencing stage in front of, and consumer of, the CLA, so operands wider than 4 bits can be added with a single 4-bit slice.
- Start/Busy/Done handshake toward the requesting logic.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and >= 4. N = WIDTH/4 nibbles.

Ports:
- CLK     input   1      rising-edge clock
- RST     input   1      synchronous reset, active-high
- Start   input   1      request; sampled only in IDLE
- A       input   WIDTH  operand A, sampled with an accepted Start
- B       input   WIDTH  operand B, sampled with an accepted Start
- Cin     input   1      carry-in, sampled with an accepted Start
- Busy    output  1      high while in RUN
- Done    output  1      one-cycle pulse; Sum/Cout have just been updated
- Sum     output  WIDTH  result, registered
- Cout    output  1      carry-out of the MSB nibble, registered

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, nibble counter=0, carry register=0, operand registers=0. RST has priority over every other event.
- State IDLE:
  - Start=1 at an edge: latch A, B, Cin into operand registers, set carry register=Cin, counter=0, go to RUN.
  - Start=0: stay in IDLE.
- State RUN (Busy=1):
  - CLA inputs: A_reg[4k+3:4k], B_reg[4k+3:4k] and the carry register, where k is the counter value.
  - At each edge: Result[3:0] is written into the internal sum register at nibble k; carry register <= Result[4]; counter increments.
  - On the edge where k = N-1: Sum <= complete sum register (including this nibble), Cout <= Result[4], go to DONE.
- State DONE: Done=1, Busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - Done is high in the cycle beginning N edges after the Start-accepting edge. For WIDTH=16 that is 4 edges.
  - Throughput is one addition per N+2 cycles when Start is held high.
- Start in RUN or DONE is ignored; there is no queueing. A and B may change freely after acceptance.
- Sum and Cout change only on the transition into DONE (or on reset). They are held stable through IDLE and the next RUN.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=4: RUN lasts exactly one cycle.
- Counter width is max(1, clog2(N)). The counter never wraps within an operation.
- RST during RUN or DONE aborts the operation. No Done pulse is produced, and Sum/Cout return to 0.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUBTRACT_EN.
- Defined:
  - An extra input port Sub (1 bit) is sampled with an accepted Start.
  - Sub=1: B_reg latches ~B and the carry register initialises to ~Cin. The result is A - B - Cin in two's complement.
  - In subtract mode Cout=1 means no borrow and Cout=0 means borrow.
  - Sub=0 behaves exactly as the base block.
- Undefined: no Sub port; addition only. Logic and latency are otherwise identical.

Test Plan:
- WIDTH=16. Reset, then Start with A=0x1234, B=0x4321, Cin=0 -> Busy high 4 cycles, Done one pulse 4 edges after accept, Sum=0x5555, Cout=0.
- A=0xFFFF, B=0x0001, Cin=0 -> carry ripples through all 4 nibbles; Sum=0x0000, Cout=1.
- A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1. Then A=0x8000, B=0x8000, Cin=0 -> Sum=0x0000, Cout=1, with no stale carry from the previous run.
- Start held high continuously with changing A/B -> only IDLE-sampled operands are used; results are spaced 6 cycles apart; Sum is stable between Done pulses.
- Start A=0x00FF, B=0x0001, assert RST on the 2nd RUN cycle -> no Done, Busy=0, Sum=0, Cout=0 the cycle after. A fresh Start afterwards yields the correct 0x0100.
- NIBBLE_SERIAL_SUBTRACT_EN defined, Sub=1:
  - A=0x0005, B=0x0007, Cin=0 -> Sum=0xFFFE, Cout=0.
  - A=0x0007, B=0x0005 -> Sum=0x0002, Cout=1.
